// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register for the 5-stage RV32I core.
// Captures decoded operands, register addresses and control bits from ID and
// presents them to the EX stage and forwarding unit one cycle later. Also holds
// the load-use hazard detector, which inserts a single bubble into EX and
// stalls PC and IF/ID while a load result is not yet available.
// Update priority per clock: Flush > ExtStall > LoadUse > normal load.
// Optional build macro: IDEX_PERF_COUNT_EN adds saturating BubbleCount and
// FlushCount outputs.
module id_ex_pipeline_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Flush,
    input  logic              ExtStall,
    input  logic              ID_Valid,
    input  logic [XLEN-1:0]   ID_PC,
    input  logic [XLEN-1:0]   ID_ReadData1,
    input  logic [XLEN-1:0]   ID_ReadData2,
    input  logic [XLEN-1:0]   ID_Imm,
    input  logic [4:0]        ID_RegisterRs1,
    input  logic [4:0]        ID_RegisterRs2,
    input  logic [4:0]        ID_RegisterRd,
    input  logic              ID_UsesRs1,
    input  logic              ID_UsesRs2,
    input  logic [2:0]        ID_Funct3,
    input  logic              ID_Funct7b5,
    input  logic              ID_RegWrite,
    input  logic              ID_MemRead,
    input  logic              ID_MemWrite,
    input  logic              ID_MemToReg,
    input  logic              ID_ALUSrc,
    input  logic              ID_Branch,
    input  logic [1:0]        ID_ALUOp,
    output logic              ID_EX_Valid,
    output logic [XLEN-1:0]   ID_EX_PC,
    output logic [XLEN-1:0]   ID_EX_ReadData1,
    output logic [XLEN-1:0]   ID_EX_ReadData2,
    output logic [XLEN-1:0]   ID_EX_Imm,
    output logic [4:0]        ID_EX_RegisterRs1,
    output logic [4:0]        ID_EX_RegisterRs2,
    output logic [4:0]        ID_EX_RegisterRd,
    output logic [2:0]        ID_EX_Funct3,
    output logic              ID_EX_Funct7b5,
    output logic              ID_EX_RegWrite,
    output logic              ID_EX_MemRead,
    output logic              ID_EX_MemWrite,
    output logic              ID_EX_MemToReg,
    output logic              ID_EX_ALUSrc,
    output logic              ID_EX_Branch,
    output logic [1:0]        ID_EX_ALUOp,
`ifdef IDEX_PERF_COUNT_EN
    output logic [CNT_W-1:0]  BubbleCount,
    output logic [CNT_W-1:0]  FlushCount,
`endif
    output logic              HazardStall
);

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic              valid_reg,     valid_next;
    logic [XLEN-1:0]   pc_reg,        pc_next;
    logic [XLEN-1:0]   rdata1_reg,    rdata1_next;
    logic [XLEN-1:0]   rdata2_reg,    rdata2_next;
    logic [XLEN-1:0]   imm_reg,       imm_next;
    logic [4:0]        rs1_reg,       rs1_next;
    logic [4:0]        rs2_reg,       rs2_next;
    logic [4:0]        rd_reg,        rd_next;
    logic [2:0]        funct3_reg,    funct3_next;
    logic              funct7b5_reg,  funct7b5_next;
    logic              reg_write_reg, reg_write_next;
    logic              mem_read_reg,  mem_read_next;
    logic              mem_write_reg, mem_write_next;
    logic              mem_to_reg_reg, mem_to_reg_next;
    logic              alu_src_reg,   alu_src_next;
    logic              branch_reg,    branch_next;
    logic [1:0]        alu_op_reg,    alu_op_next;

    logic              load_use;
    logic              rs1_match;
    logic              rs2_match;
    logic              take_bubble;
    logic              take_hold;

    // Load-use detection: the load in EX produces its result too late for the
    // instruction in ID. Bubbles and x0 destinations never create a hazard.
    always_comb begin
        rs1_match   = ID_UsesRs1 && (ID_RegisterRs1 == rd_reg);
        rs2_match   = ID_UsesRs2 && (ID_RegisterRs2 == rd_reg);
        load_use    = valid_reg && mem_read_reg && (rd_reg != 5'd0) &&
                      ID_Valid && (rs1_match || rs2_match);
        // A flush kills the dependent instruction, so no stall is needed.
        HazardStall = load_use && !Flush;
        take_bubble = Flush || (!ExtStall && load_use);
        take_hold   = !Flush && ExtStall;
    end

    // Next-state selection: bubble, hold, or capture ID (invalid ID captures
    // data fields but forces control bits and Rd to zero).
    always_comb begin
        // default: hold current contents
        valid_next      = valid_reg;
        pc_next         = pc_reg;
        rdata1_next     = rdata1_reg;
        rdata2_next     = rdata2_reg;
        imm_next        = imm_reg;
        rs1_next        = rs1_reg;
        rs2_next        = rs2_reg;
        rd_next         = rd_reg;
        funct3_next     = funct3_reg;
        funct7b5_next   = funct7b5_reg;
        reg_write_next  = reg_write_reg;
        mem_read_next   = mem_read_reg;
        mem_write_next  = mem_write_reg;
        mem_to_reg_next = mem_to_reg_reg;
        alu_src_next    = alu_src_reg;
        branch_next     = branch_reg;
        alu_op_next     = alu_op_reg;

        if (take_bubble) begin
            // Rd = 0 keeps the forwarding unit from matching on a bubble.
            valid_next      = 1'b0;
            pc_next         = '0;
            rdata1_next     = '0;
            rdata2_next     = '0;
            imm_next        = '0;
            rs1_next        = 5'd0;
            rs2_next        = 5'd0;
            rd_next         = 5'd0;
            funct3_next     = 3'd0;
            funct7b5_next   = 1'b0;
            reg_write_next  = 1'b0;
            mem_read_next   = 1'b0;
            mem_write_next  = 1'b0;
            mem_to_reg_next = 1'b0;
            alu_src_next    = 1'b0;
            branch_next     = 1'b0;
            alu_op_next     = 2'd0;
        end else if (!take_hold) begin
            valid_next      = ID_Valid;
            pc_next         = ID_PC;
            rdata1_next     = ID_ReadData1;
            rdata2_next     = ID_ReadData2;
            imm_next        = ID_Imm;
            rs1_next        = ID_RegisterRs1;
            rs2_next        = ID_RegisterRs2;
            funct3_next     = ID_Funct3;
            funct7b5_next   = ID_Funct7b5;
            rd_next         = ID_Valid ? ID_RegisterRd : 5'd0;
            reg_write_next  = ID_Valid && ID_RegWrite;
            mem_read_next   = ID_Valid && ID_MemRead;
            mem_write_next  = ID_Valid && ID_MemWrite;
            mem_to_reg_next = ID_Valid && ID_MemToReg;
            alu_src_next    = ID_Valid && ID_ALUSrc;
            branch_next     = ID_Valid && ID_Branch;
            alu_op_next     = ID_Valid ? ID_ALUOp : 2'd0;
        end
    end

    // Pipeline register with asynchronous clear; reset discards EX contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg      <= 1'b0;
            pc_reg         <= '0;
            rdata1_reg     <= '0;
            rdata2_reg     <= '0;
            imm_reg        <= '0;
            rs1_reg        <= 5'd0;
            rs2_reg        <= 5'd0;
            rd_reg         <= 5'd0;
            funct3_reg     <= 3'd0;
            funct7b5_reg   <= 1'b0;
            reg_write_reg  <= 1'b0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_to_reg_reg <= 1'b0;
            alu_src_reg    <= 1'b0;
            branch_reg     <= 1'b0;
            alu_op_reg     <= 2'd0;
        end else begin
            valid_reg      <= valid_next;
            pc_reg         <= pc_next;
            rdata1_reg     <= rdata1_next;
            rdata2_reg     <= rdata2_next;
            imm_reg        <= imm_next;
            rs1_reg        <= rs1_next;
            rs2_reg        <= rs2_next;
            rd_reg         <= rd_next;
            funct3_reg     <= funct3_next;
            funct7b5_reg   <= funct7b5_next;
            reg_write_reg  <= reg_write_next;
            mem_read_reg   <= mem_read_next;
            mem_write_reg  <= mem_write_next;
            mem_to_reg_reg <= mem_to_reg_next;
            alu_src_reg    <= alu_src_next;
            branch_reg     <= branch_next;
            alu_op_reg     <= alu_op_next;
        end
    end

    assign ID_EX_Valid       = valid_reg;
    assign ID_EX_PC          = pc_reg;
    assign ID_EX_ReadData1   = rdata1_reg;
    assign ID_EX_ReadData2   = rdata2_reg;
    assign ID_EX_Imm         = imm_reg;
    assign ID_EX_RegisterRs1 = rs1_reg;
    assign ID_EX_RegisterRs2 = rs2_reg;
    assign ID_EX_RegisterRd  = rd_reg;
    assign ID_EX_Funct3      = funct3_reg;
    assign ID_EX_Funct7b5    = funct7b5_reg;
    assign ID_EX_RegWrite    = reg_write_reg;
    assign ID_EX_MemRead     = mem_read_reg;
    assign ID_EX_MemWrite    = mem_write_reg;
    assign ID_EX_MemToReg    = mem_to_reg_reg;
    assign ID_EX_ALUSrc      = alu_src_reg;
    assign ID_EX_Branch      = branch_reg;
    assign ID_EX_ALUOp       = alu_op_reg;

`ifdef IDEX_PERF_COUNT_EN
    logic [CNT_W-1:0] bubble_count_reg;
    logic [CNT_W-1:0] flush_count_reg;
    logic             bubble_event;
    logic             flush_event;

    // Flush outranks ExtStall, so a flush always counts; load-use bubbles
    // only count when ExtStall is not holding the register.
    assign flush_event  = Flush;
    assign bubble_event = !Flush && !ExtStall && load_use;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_count_reg <= '0;
            flush_count_reg  <= '0;
        end else begin
            if (bubble_event && !(&bubble_count_reg))
                bubble_count_reg <= bubble_count_reg + 1'b1;
            if (flush_event && !(&flush_count_reg))
                flush_count_reg <= flush_count_reg + 1'b1;
        end
    end

    assign BubbleCount = bubble_count_reg;
    assign FlushCount  = flush_count_reg;
`endif

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Directed testbench for id_ex_pipeline_reg. Inputs change 1 time unit after
// a rising edge; outputs are sampled 1 time unit after the edge.
// Optional build macro: IDEX_PERF_COUNT_EN enables the counter checks.
module tb_id_ex_pipeline_reg;

    logic        clk;
    logic        rst_n;
    logic        Flush;
    logic        ExtStall;
    logic        ID_Valid;
    logic [31:0] ID_PC;
    logic [31:0] ID_ReadData1;
    logic [31:0] ID_ReadData2;
    logic [31:0] ID_Imm;
    logic [4:0]  ID_RegisterRs1;
    logic [4:0]  ID_RegisterRs2;
    logic [4:0]  ID_RegisterRd;
    logic        ID_UsesRs1;
    logic        ID_UsesRs2;
    logic [2:0]  ID_Funct3;
    logic        ID_Funct7b5;
    logic        ID_RegWrite;
    logic        ID_MemRead;
    logic        ID_MemWrite;
    logic        ID_MemToReg;
    logic        ID_ALUSrc;
    logic        ID_Branch;
    logic [1:0]  ID_ALUOp;
    logic        ID_EX_Valid;
    logic [31:0] ID_EX_PC;
    logic [31:0] ID_EX_ReadData1;
    logic [31:0] ID_EX_ReadData2;
    logic [31:0] ID_EX_Imm;
    logic [4:0]  ID_EX_RegisterRs1;
    logic [4:0]  ID_EX_RegisterRs2;
    logic [4:0]  ID_EX_RegisterRd;
    logic [2:0]  ID_EX_Funct3;
    logic        ID_EX_Funct7b5;
    logic        ID_EX_RegWrite;
    logic        ID_EX_MemRead;
    logic        ID_EX_MemWrite;
    logic        ID_EX_MemToReg;
    logic        ID_EX_ALUSrc;
    logic        ID_EX_Branch;
    logic [1:0]  ID_EX_ALUOp;
    logic        HazardStall;
`ifdef IDEX_PERF_COUNT_EN
    logic [31:0] BubbleCount;
    logic [31:0] FlushCount;
`endif

    int errors = 0;
    int checks = 0;

    id_ex_pipeline_reg #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .Flush(Flush), .ExtStall(ExtStall),
        .ID_Valid(ID_Valid), .ID_PC(ID_PC),
        .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_Imm(ID_Imm),
        .ID_RegisterRs1(ID_RegisterRs1), .ID_RegisterRs2(ID_RegisterRs2),
        .ID_RegisterRd(ID_RegisterRd), .ID_UsesRs1(ID_UsesRs1), .ID_UsesRs2(ID_UsesRs2),
        .ID_Funct3(ID_Funct3), .ID_Funct7b5(ID_Funct7b5),
        .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
        .ID_MemToReg(ID_MemToReg), .ID_ALUSrc(ID_ALUSrc), .ID_Branch(ID_Branch),
        .ID_ALUOp(ID_ALUOp),
        .ID_EX_Valid(ID_EX_Valid), .ID_EX_PC(ID_EX_PC),
        .ID_EX_ReadData1(ID_EX_ReadData1), .ID_EX_ReadData2(ID_EX_ReadData2),
        .ID_EX_Imm(ID_EX_Imm), .ID_EX_RegisterRs1(ID_EX_RegisterRs1),
        .ID_EX_RegisterRs2(ID_EX_RegisterRs2), .ID_EX_RegisterRd(ID_EX_RegisterRd),
        .ID_EX_Funct3(ID_EX_Funct3), .ID_EX_Funct7b5(ID_EX_Funct7b5),
        .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
        .ID_EX_MemWrite(ID_EX_MemWrite), .ID_EX_MemToReg(ID_EX_MemToReg),
        .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_Branch(ID_EX_Branch),
        .ID_EX_ALUOp(ID_EX_ALUOp),
`ifdef IDEX_PERF_COUNT_EN
        .BubbleCount(BubbleCount), .FlushCount(FlushCount),
`endif
        .HazardStall(HazardStall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        Flush = 0; ExtStall = 0; ID_Valid = 0; ID_PC = 0;
        ID_ReadData1 = 0; ID_ReadData2 = 0; ID_Imm = 0;
        ID_RegisterRs1 = 0; ID_RegisterRs2 = 0; ID_RegisterRd = 0;
        ID_UsesRs1 = 0; ID_UsesRs2 = 0; ID_Funct3 = 0; ID_Funct7b5 = 0;
        ID_RegWrite = 0; ID_MemRead = 0; ID_MemWrite = 0; ID_MemToReg = 0;
        ID_ALUSrc = 0; ID_Branch = 0; ID_ALUOp = 0;
    endtask

    // Present one instruction in ID.
    task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] rd1,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic u1, input logic u2, input logic rw, input logic mr);
        ID_Valid = v; ID_PC = pc; ID_ReadData1 = rd1; ID_ReadData2 = rd1 + 32'd1;
        ID_Imm = 32'h10; ID_RegisterRs1 = rs1; ID_RegisterRs2 = rs2; ID_RegisterRd = rd;
        ID_UsesRs1 = u1; ID_UsesRs2 = u2; ID_RegWrite = rw; ID_MemRead = mr;
        ID_MemToReg = mr; ID_Funct3 = mr ? 3'd2 : 3'd0; ID_ALUOp = mr ? 2'd0 : 2'd2;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_id();
        #12;
        checks++; if (ID_EX_Valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b exp=0", ID_EX_Valid); end
        checks++; if (ID_EX_PC !== 32'd0) begin errors++; $display("FAIL rst_pc got=%h exp=0", ID_EX_PC); end
        checks++; if (ID_EX_RegisterRd !== 5'd0) begin errors++; $display("FAIL rst_rd got=%0d exp=0", ID_EX_RegisterRd); end
        checks++; if (HazardStall !== 1'b0) begin errors++; $display("FAIL rst_hazard got=%0b exp=0", HazardStall); end
`ifdef IDEX_PERF_COUNT_EN
        checks++; if (BubbleCount !== 32'd0) begin errors++; $display("FAIL rst_bcnt got=%0d exp=0", BubbleCount); end
`endif
        @(negedge clk);
        rst_n = 1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_advance();
        set_id(1, 32'h40, 32'h1234, 5'd1, 5'd2, 5'd5, 1, 1, 1, 0);
        #1;
        checks++; if (HazardStall !== 1'b0) begin errors++; $display("FAIL adv_hazard got=%0b exp=0", HazardStall); end
        checks++; if (ID_EX_Valid !== 1'b0) begin errors++; $display("FAIL adv_nocomb got=%0b exp=0", ID_EX_Valid); end
        tick();
        checks++; if (ID_EX_RegisterRd !== 5'd5) begin errors++; $display("FAIL adv_rd got=%0d exp=5", ID_EX_RegisterRd); end
        checks++; if (ID_EX_RegWrite !== 1'b1) begin errors++; $display("FAIL adv_rw got=%0b exp=1", ID_EX_RegWrite); end
        checks++; if (ID_EX_ReadData1 !== 32'h1234) begin errors++; $display("FAIL adv_rd1 got=%h exp=1234", ID_EX_ReadData1); end
        checks++; if (ID_EX_ReadData2 !== 32'h1235) begin errors++; $display("FAIL adv_rd2 got=%h exp=1235", ID_EX_ReadData2); end
        checks++; if (ID_EX_PC !== 32'h40) begin errors++; $display("FAIL adv_pc got=%h exp=40", ID_EX_PC); end
        checks++; if (ID_EX_Valid !== 1'b1) begin errors++; $display("FAIL adv_valid got=%0b exp=1", ID_EX_Valid); end
        checks++; if (ID_EX_ALUOp !== 2'd2) begin errors++; $display("FAIL adv_aluop got=%0d exp=2", ID_EX_ALUOp); end
        // second instruction back-to-back
        set_id(1, 32'h44, 32'h5678, 5'd3, 5'd4, 5'd6, 1, 1, 1, 0);
        tick();
        checks++; if (ID_EX_PC !== 32'h44 || ID_EX_RegisterRd !== 5'd6) begin errors++; $display("FAIL b2b_pc_rd got=%h/%0d exp=44/6", ID_EX_PC, ID_EX_RegisterRd); end
        $display("test_advance done");
    endtask

    task automatic test_load_use();
        set_id(1, 32'h80, 32'h0, 5'd2, 5'd0, 5'd7, 1, 0, 1, 1);   // lw x7
        tick();
        set_id(1, 32'h84, 32'h99, 5'd3, 5'd7, 5'd8, 1, 1, 1, 0);  // add x8,x3,x7
        #1;
        checks++; if (HazardStall !== 1'b1) begin errors++; $display("FAIL lu_hazard got=%0b exp=1", HazardStall); end
        tick();
        checks++; if (ID_EX_Valid !== 1'b0 || ID_EX_RegWrite !== 1'b0 || ID_EX_RegisterRd !== 5'd0) begin errors++; $display("FAIL lu_bubble got=v%0b rw%0b rd%0d exp=v0 rw0 rd0", ID_EX_Valid, ID_EX_RegWrite, ID_EX_RegisterRd); end
        checks++; if (ID_EX_MemRead !== 1'b0) begin errors++; $display("FAIL lu_bubble_mr got=%0b exp=0", ID_EX_MemRead); end
        checks++; if (HazardStall !== 1'b0) begin errors++; $display("FAIL lu_release got=%0b exp=0", HazardStall); end
        tick();
        checks++; if (ID_EX_Valid !== 1'b1 || ID_EX_RegisterRd !== 5'd8 || ID_EX_RegisterRs2 !== 5'd7) begin errors++; $display("FAIL lu_add got=v%0b rd%0d rs2%0d exp=v1 rd8 rs2 7", ID_EX_Valid, ID_EX_RegisterRd, ID_EX_RegisterRs2); end
        $display("test_load_use done");
    endtask

    task automatic test_false_dep();
        set_id(1, 32'h90, 32'h0, 5'd2, 5'd0, 5'd7, 1, 0, 1, 1);   // lw x7
        tick();
        set_id(1, 32'h94, 32'h0, 5'd7, 5'd0, 5'd9, 0, 0, 1, 0);   // lui x9 (rs1 field 7)
        #1;
        checks++; if (HazardStall !== 1'b0) begin errors++; $display("FAIL fd_hazard got=%0b exp=0", HazardStall); end
        tick();
        checks++; if (ID_EX_RegisterRd !== 5'd9 || ID_EX_Valid !== 1'b1) begin errors++; $display("FAIL fd_load got=rd%0d v%0b exp=rd9 v1", ID_EX_RegisterRd, ID_EX_Valid); end
        // lw to x0 never stalls
        set_id(1, 32'h98, 32'h0, 5'd2, 5'd0, 5'd0, 1, 0, 1, 1);
        tick();
        set_id(1, 32'h9C, 32'h0, 5'd0, 5'd0, 5'd10, 1, 0, 1, 0);
        #1;
        checks++; if (HazardStall !== 1'b0) begin errors++; $display("FAIL x0_hazard got=%0b exp=0", HazardStall); end
        tick();
        $display("test_false_dep done");
    endtask

    task automatic test_stall_flush();
        // ExtStall with load-use pending: hold, HazardStall stays high
        set_id(1, 32'hA0, 32'h0, 5'd2, 5'd0, 5'd7, 1, 0, 1, 1);   // lw x7
        tick();
        set_id(1, 32'hA4, 32'h0, 5'd7, 5'd0, 5'd11, 1, 0, 1, 0);
        ExtStall = 1;
        #1;
        checks++; if (HazardStall !== 1'b1) begin errors++; $display("FAIL es_lu_hazard got=%0b exp=1", HazardStall); end
        tick();
        checks++; if (ID_EX_MemRead !== 1'b1 || ID_EX_RegisterRd !== 5'd7 || HazardStall !== 1'b1) begin errors++; $display("FAIL es_lu_hold got=mr%0b rd%0d hz%0b exp=mr1 rd7 hz1", ID_EX_MemRead, ID_EX_RegisterRd, HazardStall); end
        // Flush and ExtStall together with load-use pending: bubble, no stall
        Flush = 1;
        #1;
        checks++; if (HazardStall !== 1'b0) begin errors++; $display("FAIL fl_hazard got=%0b exp=0", HazardStall); end
        tick();
        checks++; if (ID_EX_Valid !== 1'b0 || ID_EX_RegisterRd !== 5'd0 || ID_EX_MemRead !== 1'b0) begin errors++; $display("FAIL fl_bubble got=v%0b rd%0d mr%0b exp=v0 rd0 mr0", ID_EX_Valid, ID_EX_RegisterRd, ID_EX_MemRead); end
        Flush = 0; ExtStall = 0;
        // ExtStall alone for 3 cycles freezes the register
        set_id(1, 32'h200, 32'hAAAA, 5'd1, 5'd2, 5'd10, 1, 1, 1, 0);
        tick();
        set_id(1, 32'h300, 32'hBBBB, 5'd3, 5'd4, 5'd11, 1, 1, 1, 0);
        ExtStall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (ID_EX_PC !== 32'h200 || ID_EX_RegisterRd !== 5'd10 || ID_EX_ReadData1 !== 32'hAAAA || ID_EX_Valid !== 1'b1) begin errors++; $display("FAIL es_hold%0d got=pc%h rd%0d d%h exp=pc200 rd10 dAAAA", i, ID_EX_PC, ID_EX_RegisterRd, ID_EX_ReadData1); end
        end
        ExtStall = 0;
        tick();
        checks++; if (ID_EX_PC !== 32'h300 || ID_EX_RegisterRd !== 5'd11) begin errors++; $display("FAIL es_resume got=pc%h rd%0d exp=pc300 rd11", ID_EX_PC, ID_EX_RegisterRd); end
        $display("test_stall_flush done");
    endtask

    task automatic test_invalid();
        set_id(0, 32'h100, 32'h77, 5'd1, 5'd2, 5'd5, 1, 1, 1, 1);
        tick();
        checks++; if (ID_EX_PC !== 32'h100) begin errors++; $display("FAIL inv_pc got=%h exp=100", ID_EX_PC); end
        checks++; if (ID_EX_Valid !== 1'b0 || ID_EX_RegWrite !== 1'b0 || ID_EX_MemRead !== 1'b0 || ID_EX_RegisterRd !== 5'd0) begin errors++; $display("FAIL inv_ctrl got=v%0b rw%0b mr%0b rd%0d exp=0 0 0 0", ID_EX_Valid, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_RegisterRd); end
        $display("test_invalid done");
    endtask

    task automatic test_reset_mid();
        set_id(1, 32'h400, 32'hCAFE, 5'd1, 5'd2, 5'd12, 1, 1, 1, 0);
        tick();
        checks++; if (ID_EX_Valid !== 1'b1) begin errors++; $display("FAIL rm_pre got=%0b exp=1", ID_EX_Valid); end
        rst_n = 0;
        #1;
        checks++; if (ID_EX_Valid !== 1'b0 || ID_EX_PC !== 32'd0 || ID_EX_RegisterRd !== 5'd0 || ID_EX_RegWrite !== 1'b0) begin errors++; $display("FAIL rm_clear got=v%0b pc%h rd%0d rw%0b exp=0", ID_EX_Valid, ID_EX_PC, ID_EX_RegisterRd, ID_EX_RegWrite); end
`ifdef IDEX_PERF_COUNT_EN
        checks++; if (BubbleCount !== 32'd0 || FlushCount !== 32'd0) begin errors++; $display("FAIL rm_cnt got=%0d/%0d exp=0/0", BubbleCount, FlushCount); end
`endif
        @(negedge clk);
        rst_n = 1;
        clear_id();
        tick();
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_advance();
        test_load_use();
        test_false_dep();
        test_stall_flush();
        test_invalid();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_pipeline_reg.md
Name: id_ex_pipeline_reg

Overview:
- ID/EX pipeline register for the 5-stage RV32I core; sits directly upstream of the EX-stage forwarding unit and ALU operand muxes.
- Captures decoded operands, register addresses and control bits from ID each cycle, and presents them as the ID_EX_* signals the forwarding unit and EX stage consume.
- Contains the load-use hazard detector: on a hazard it inserts a bubble into EX and stalls PC and IF/ID.
- Also handles flush from branch resolution and hold from an external memory stall.

Parameters:
- XLEN, 32, datapath width for PC, register data and immediate.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Flush  in  1  branch/jump taken in EX; kill the instruction entering EX.
- ExtStall  in  1  memory-side stall; hold all pipeline state.
- ID_Valid  in  1  IF/ID holds a real instruction.
- ID_PC  in  XLEN  PC of the instruction in ID.
- ID_ReadData1, ID_ReadData2  in  XLEN  register file read data.
- ID_Imm  in  XLEN  sign-extended immediate.
- ID_RegisterRs1, ID_RegisterRs2, ID_RegisterRd  in  5  register addresses.
- ID_UsesRs1, ID_UsesRs2  in  1  decoder flags; the instruction actually reads rs1/rs2.
- ID_Funct3  in  3; ID_Funct7b5  in  1.
- ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc, ID_Branch  in  1  control bits.
- ID_ALUOp  in  2.
- ID_EX_*  out  (same widths)  registered copies of every ID_* input above, except the Uses flags.
- ID_EX_Valid  out  1  EX holds a real instruction.
- HazardStall  out  1  combinational; hold PC and IF/ID this cycle.

Behaviour:
- Reset (rst_n low, asynchronous): all ID_EX_* outputs are 0, including ID_EX_Valid. A reset asserted mid-operation discards the in-flight instruction immediately.
- Load-use hazard, combinational: LoadUse = ID_EX_Valid & ID_EX_MemRead & (ID_EX_RegisterRd != 0) & ID_Valid & ((ID_UsesRs1 & ID_RegisterRs1 == ID_EX_RegisterRd) | (ID_UsesRs2 & ID_RegisterRs2 == ID_EX_RegisterRd)).
- HazardStall = LoadUse & ~Flush. A flush kills the dependent instruction, so no stall is needed.
- Update priority at each rising clk, highest first:
  1. Flush: load a bubble.
  2. ExtStall: hold all registers unchanged.
  3. LoadUse: load a bubble.
  4. Otherwise: load all ID_* inputs, with ID_EX_Valid = ID_Valid.
- Bubble definition: ID_EX_Valid, RegWrite, MemRead, MemWrite, MemToReg, Branch, ALUOp and RegisterRd/Rs1/Rs2 all 0. Data fields (PC, ReadData, Imm, funct) are don't-care; the implementation clears them to 0.
- Bubble Rd = 0 guarantees the forwarding unit never matches on a bubble.
- ID_Valid = 0 loads normally, but all control bits and Rd are forced to 0 (a bubble with PC captured).
- ExtStall & LoadUse together: register holds, HazardStall stays 1. The dependency is re-evaluated every cycle, so the stall persists until the load leaves EX.
- Latency: exactly 1 cycle from ID_* to ID_EX_* when not stalled. No combinational path from ID_* to ID_EX_*.
- Back-to-back load-use: the bubble makes LoadUse 0 in the next cycle, so the stalled instruction advances on the second cycle. A load-use stall is always exactly 1 bubble absent ExtStall.

Optional Feature:
- Macro: IDEX_PERF_COUNT_EN.
- Defined:
  - Extra outputs BubbleCount and FlushCount (CNT_W each).
  - BubbleCount increments on each clock where a LoadUse bubble is loaded.
  - FlushCount increments on each clock where Flush is taken.
  - Both are counted only when ExtStall does not take priority.
  - Both saturate at all-ones and reset to 0 asynchronously.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Plain advance: ID_Valid=1, Rd=5, RegWrite=1, ReadData1=0x1234 -> next cycle ID_EX_RegisterRd=5, ID_EX_RegWrite=1, ID_EX_ReadData1=0x1234, ID_EX_Valid=1, HazardStall=0.
- Load-use: EX holds lw with Rd=7; ID has add with Rs2=7, UsesRs2=1 -> HazardStall=1 that cycle; next cycle ID_EX_Valid=0, RegWrite=0, Rd=0; following cycle the add loads, HazardStall=0.
- False dependency: EX lw Rd=7; ID lui with Rs1 field=7, UsesRs1=0 -> HazardStall=0, lui loads next cycle.
- x0 load: EX lw Rd=0; ID uses Rs1=0 -> HazardStall=0.
- Flush vs stall: Flush=1 and ExtStall=1 with a load-use pending -> next cycle bubble, HazardStall=0; ExtStall alone for 3 cycles -> outputs frozen for 3 cycles.
- Reset mid-operation: rst_n low between clock edges while ID_EX_Valid=1 -> all outputs 0 immediately. With IDEX_PERF_COUNT_EN defined, counters read 0; with BubbleCount preloaded to 0xFFFFFFFF, a further bubble leaves it at 0xFFFFFFFF.
